// File: rtl/types_pkg.sv
// Shared types for the LED display block: BCD time of day,
// controller states, frame timing and 7-segment codes.
package types_pkg;

    typedef struct packed {
        logic [3:0] t_10h;
        logic [3:0] t_1h;
        logic [3:0] t_10m;
        logic [3:0] t_1m;
        logic [3:0] t_10s;
        logic [3:0] t_1s;
        logic [3:0] t_100ms;
        logic [3:0] t_10ms;
        logic [3:0] t_1ms;
    } time_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FETCH,
        ST_SHIFT,
        ST_LATCH
    } disp_state_t;

    localparam logic [8:0] FETCH_LAST = 9'd4;
    localparam logic [8:0] SHIFT_LAST = 9'd511;
    localparam logic [8:0] LATCH_LAST = 9'd1;

    localparam logic [7:0] SEG_0     = 8'h3F;
    localparam logic [7:0] SEG_1     = 8'h06;
    localparam logic [7:0] SEG_2     = 8'h5B;
    localparam logic [7:0] SEG_3     = 8'h4F;
    localparam logic [7:0] SEG_4     = 8'h66;
    localparam logic [7:0] SEG_5     = 8'h6D;
    localparam logic [7:0] SEG_6     = 8'h7D;
    localparam logic [7:0] SEG_7     = 8'h07;
    localparam logic [7:0] SEG_8     = 8'h7F;
    localparam logic [7:0] SEG_9     = 8'h6F;
    localparam logic [7:0] SEG_BLANK = 8'h00;
    localparam logic [7:0] SEG_DP    = 8'h80;

    function automatic logic [7:0] seg7(input logic [3:0] d);
        logic [7:0] s;
        case (d)
            4'd0:    s = SEG_0;
            4'd1:    s = SEG_1;
            4'd2:    s = SEG_2;
            4'd3:    s = SEG_3;
            4'd4:    s = SEG_4;
            4'd5:    s = SEG_5;
            4'd6:    s = SEG_6;
            4'd7:    s = SEG_7;
            4'd8:    s = SEG_8;
            4'd9:    s = SEG_9;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/disp_sram.sv
// 1024x32 frame RAM: CPU read/write port A, display read port B.
// Reads are registered and return pre-write data on a collision.
module disp_sram (
    input  logic        clk,
    input  logic        rst,
    input  logic [9:0]  i_a_addr,
    input  logic        i_a_we,
    input  logic [31:0] i_a_wdata,
    output logic [31:0] o_a_rdata,
    input  logic [9:0]  i_b_addr,
    output logic [31:0] o_b_rdata
);

    logic [31:0] r_mem [1024];
    logic [31:0] r_a_rdata;
    logic [31:0] r_b_rdata;

    // Contents survive reset; only the read registers clear.
    always_ff @(posedge clk) begin
        if (i_a_we) begin
            r_mem[i_a_addr] <= i_a_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a_rdata <= '0;
            r_b_rdata <= '0;
        end else begin
            r_a_rdata <= r_mem[i_a_addr];
            r_b_rdata <= r_mem[i_b_addr];
        end
    end

    assign o_a_rdata = r_a_rdata;
    assign o_b_rdata = r_b_rdata;

endmodule

// File: rtl/disp.sv
// TLC59282 LED display controller: frame fetch from RAM, clock
// overlay on page 0, serial shift-out, latch and PDM dimming.
module disp
    import types_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        tsc_1pps,
    input  logic        tsc_1ppms,
    input  logic        tsc_1ppus,
    input  logic        disp_ena,
    input  logic [7:0]  disp_page,
    input  logic [7:0]  disp_pdm,
    input  logic [3:0]  stat_src,
    input  logic [15:0] stat,
    input  logic [9:0]  sram_addr,
    input  logic        sram_we,
    input  logic [31:0] sram_datao,
    output logic [31:0] sram_datai,
    input  time_t       cur_time,
    output logic        disp_sclk,
    output logic        disp_blank,
    output logic        disp_lat,
    output logic        disp_sin,
    output logic        disp_status
);

    disp_state_t  r_state;
    disp_state_t  w_next;
    logic [8:0]   r_cnt;
    logic [127:0] r_sreg;
    logic [7:0]   r_page;
    time_t        r_time;
    logic         r_dp;
    logic         r_colon;
    logic [7:0]   r_acc;
    logic         r_blank;
    logic         r_status;

    logic         w_start;
    logic         w_load;
    logic         w_last;
    logic         w_shift;
    logic [9:0]   w_rd_addr;
    logic [31:0]  w_rd_data;
    logic [127:0] w_overlay;
    logic [7:0]   w_dp;
    logic [8:0]   w_sum;

    disp_sram u_sram (
        .clk       (clk),
        .rst       (rst),
        .i_a_addr  (sram_addr),
        .i_a_we    (sram_we),
        .i_a_wdata (sram_datao),
        .o_a_rdata (sram_datai),
        .i_b_addr  (w_rd_addr),
        .o_b_rdata (w_rd_data)
    );

    assign w_start   = tsc_1ppms & disp_ena & (r_state == ST_IDLE);
    assign w_rd_addr = {r_page, r_cnt[1:0]};
    assign w_load    = (r_state == ST_FETCH) & (r_cnt != 9'd0);
    assign w_last    = (r_cnt == FETCH_LAST);
    assign w_shift   = (r_state == ST_SHIFT) & (r_cnt[1:0] == 2'b11);
    assign w_dp      = r_dp ? SEG_DP : 8'h00;
    assign w_sum     = {1'b0, r_acc} + {1'b0, disp_pdm};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:  if (w_start) w_next = ST_FETCH;
            ST_FETCH: if (r_cnt == FETCH_LAST) w_next = ST_SHIFT;
            ST_SHIFT: if (r_cnt == SHIFT_LAST) w_next = ST_LATCH;
            ST_LATCH: if (r_cnt == LATCH_LAST) w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        disp_sclk = 1'b0;
        disp_lat  = 1'b0;
        disp_sin  = 1'b0;
        case (r_state)
            ST_SHIFT: begin
                disp_sclk = r_cnt[1];
                disp_sin  = r_sreg[127];
            end
            ST_LATCH: disp_lat = 1'b1;
            default: ;
        endcase
    end

    // Clock digits occupy bytes 0..8; colon dots sit on bytes 1 and 3.
    always_comb begin
        w_overlay = '0;
        if (r_page == 8'h00) begin
            w_overlay[127:56] = {
                seg7(r_time.t_10h),
                seg7(r_time.t_1h) | w_dp,
                seg7(r_time.t_10m),
                seg7(r_time.t_1m) | w_dp,
                seg7(r_time.t_10s),
                seg7(r_time.t_1s),
                seg7(r_time.t_100ms),
                seg7(r_time.t_10ms),
                seg7(r_time.t_1ms)
            };
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt  <= '0;
            r_sreg <= '0;
            r_page <= '0;
            r_time <= '0;
            r_dp   <= 1'b0;
        end else begin
            if (w_next != r_state) begin
                r_cnt <= '0;
            end else if (r_state != ST_IDLE) begin
                r_cnt <= r_cnt + 9'd1;
            end
            if (w_start) begin
                r_page <= disp_page;
                r_time <= cur_time;
                r_dp   <= r_colon;
            end
            // Read data lags the address by one clk, so words land on clks 1..4.
            if (w_load) begin
                r_sreg <= {r_sreg[95:0], w_rd_data} | (w_last ? w_overlay : '0);
            end else if (w_shift) begin
                r_sreg <= {r_sreg[126:0], 1'b0};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_colon  <= 1'b0;
            r_acc    <= '0;
            r_blank  <= 1'b1;
            r_status <= 1'b0;
        end else begin
            if (tsc_1pps) begin
                r_colon <= ~r_colon;
            end
            if (tsc_1ppus) begin
                r_acc <= w_sum[7:0];
            end
            if (!disp_ena) begin
                r_blank <= 1'b1;
            end else if (tsc_1ppus) begin
                r_blank <= ~w_sum[8];
            end
            r_status <= stat[stat_src];
        end
    end

    assign disp_blank  = r_blank;
    assign disp_status = r_status;

endmodule

// File: tb/tb_disp.sv
// Self-checking bench for disp: behavioural frame/PDM/RAM model
// compared every clk, plus directed literal scenarios.
module tb_disp;
    import types_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        tsc_1pps = 1'b0;
    logic        tsc_1ppms = 1'b0;
    logic        tsc_1ppus = 1'b0;
    logic        disp_ena = 1'b0;
    logic [7:0]  disp_page = '0;
    logic [7:0]  disp_pdm = '0;
    logic [3:0]  stat_src = '0;
    logic [15:0] stat = '0;
    logic [9:0]  sram_addr = '0;
    logic        sram_we = 1'b0;
    logic [31:0] sram_datao = '0;
    logic [31:0] sram_datai;
    time_t       cur_time = '0;
    logic        disp_sclk;
    logic        disp_blank;
    logic        disp_lat;
    logic        disp_sin;
    logic        disp_status;

    always #5 clk = ~clk;

    disp dut (
        .clk         (clk),
        .rst         (rst),
        .tsc_1pps    (tsc_1pps),
        .tsc_1ppms   (tsc_1ppms),
        .tsc_1ppus   (tsc_1ppus),
        .disp_ena    (disp_ena),
        .disp_page   (disp_page),
        .disp_pdm    (disp_pdm),
        .stat_src    (stat_src),
        .stat        (stat),
        .sram_addr   (sram_addr),
        .sram_we     (sram_we),
        .sram_datao  (sram_datao),
        .sram_datai  (sram_datai),
        .cur_time    (cur_time),
        .disp_sclk   (disp_sclk),
        .disp_blank  (disp_blank),
        .disp_lat    (disp_lat),
        .disp_sin    (disp_sin),
        .disp_status (disp_status)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            if (failures <= 40)
                $display("FAIL %s got=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [7:0]  seg_tab [10] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66,
                                  8'h6D, 8'h7D, 8'h07, 8'h7F, 8'h6F};
    logic [31:0] mmem [1024];
    bit          mvalid [1024];
    bit          mbusy = 0;
    int          mn = 0;
    logic [7:0]  mpage = '0;
    time_t       mtime = '0;
    bit          mdp = 0;
    logic [31:0] mword [4];
    bit          mcolon = 0;
    int          macc = 0;
    bit          mblank = 1;
    bit          mstatus = 0;
    logic [31:0] mrd = '0;
    bit          mrd_ok = 0;
    bit          cmp_on = 0;

    function automatic logic [7:0] seg(input logic [3:0] d);
        return (d <= 4'd9) ? seg_tab[d] : 8'h00;
    endfunction

    function automatic logic [127:0] model_frame();
        logic [127:0] f;
        logic [3:0]   dig [9];
        logic [7:0]   b;
        f = {mword[0], mword[1], mword[2], mword[3]};
        dig = '{mtime.t_10h, mtime.t_1h, mtime.t_10m, mtime.t_1m, mtime.t_10s,
                mtime.t_1s, mtime.t_100ms, mtime.t_10ms, mtime.t_1ms};
        if (mpage == 8'h00) begin
            for (int k = 0; k < 9; k++) begin
                b = seg(dig[k]);
                if (mdp && (k == 1 || k == 3)) b = b | 8'h80;
                f[127-8*k -: 8] = f[127-8*k -: 8] | b;
            end
        end
        return f;
    endfunction

    always @(posedge clk) begin
        int sum;
        if (rst) begin
            mbusy = 0; mcolon = 0; macc = 0; mblank = 1;
            mstatus = 0; mrd = '0; mrd_ok = 1;
        end else begin
            mrd = mmem[sram_addr];
            mrd_ok = mvalid[sram_addr];
            mstatus = stat[stat_src];
            if (mbusy) begin
                // word w of the page is read at clk w of the frame
                if (mn < 4) mword[mn] = mmem[{mpage, mn[1:0]}];
                mn++;
                if (mn == 519) mbusy = 0;
            end else if (tsc_1ppms && disp_ena) begin
                mbusy = 1; mn = 0; mpage = disp_page;
                mtime = cur_time; mdp = mcolon;
            end
            if (sram_we) begin
                mmem[sram_addr] = sram_datao;
                mvalid[sram_addr] = 1;
            end
            if (tsc_1pps) mcolon = !mcolon;
            sum = macc + int'(disp_pdm);
            if (tsc_1ppus) macc = sum % 256;
            if (!disp_ena) mblank = 1;
            else if (tsc_1ppus) mblank = (sum < 256);
        end
    end

    always @(posedge clk) begin
        logic esclk, elat, esin;
        logic [127:0] fr;
        int k;
        #1;
        if (cmp_on) begin
            esclk = 0; elat = 0; esin = 0;
            if (mbusy && mn >= 5 && mn < 517) begin
                k = mn - 5;
                fr = model_frame();
                esclk = ((k % 4) >= 2);
                esin = fr[127 - k/4];
            end else if (mbusy && mn >= 517) begin
                elat = 1;
            end
            chk("sclk", disp_sclk, esclk);
            chk("lat", disp_lat, elat);
            chk("sin", disp_sin, esin);
            chk("blank", disp_blank, mblank);
            chk("status", disp_status, mstatus);
            if (mrd_ok) chk("sram_datai", sram_datai, mrd);
        end
    end

    // ---------------- directed helpers ----------------
    task automatic run_frame(output logic [127:0] bits, output int lat_first,
                             output int lat_cnt, output int rises);
        logic prev;
        bits = '0; lat_first = -1; lat_cnt = 0; rises = 0; prev = 0;
        tsc_1ppms = 1'b1;
        @(negedge clk);
        tsc_1ppms = 1'b0;
        for (int c = 0; c < 525; c++) begin
            if (disp_sclk && !prev) begin
                rises++;
                bits = {bits[126:0], disp_sin};
            end
            prev = disp_sclk;
            if (disp_lat) begin
                if (lat_first < 0) lat_first = c;
                lat_cnt++;
            end
            @(negedge clk);
        end
    endtask

    task automatic pdm_count(input logic [7:0] pdm, output int lows);
        disp_pdm = pdm;
        lows = 0;
        for (int s = 0; s < 256; s++) begin
            tsc_1ppus = 1'b1;
            @(negedge clk);
            tsc_1ppus = 1'b0;
            if (!disp_blank) lows++;
            @(negedge clk);
        end
    endtask

    initial begin
        logic [127:0] bits;
        int lf, lc, rs, lows;
        logic [63:0] t64;

        repeat (3) @(negedge clk);
        rst = 1'b0;
        cmp_on = 1;
        chk("rst_sclk", disp_sclk, 1'b0);
        chk("rst_lat", disp_lat, 1'b0);
        chk("rst_sin", disp_sin, 1'b0);
        chk("rst_blank", disp_blank, 1'b1);
        chk("rst_status", disp_status, 1'b0);
        chk("rst_datai", sram_datai, 32'h0);

        // fill RAM; pages 0x00 and 0x08 cleared, 0x020 marked
        for (int a = 0; a < 1024; a++) begin
            sram_we = 1'b1;
            sram_addr = 10'(a);
            if (a == 10'h020) sram_datao = 32'h8000_0001;
            else if (a < 4 || (a >= 32 && a < 36)) sram_datao = 32'h0;
            else sram_datao = $urandom();
            @(negedge clk);
        end
        sram_we = 1'b0;

        sram_addr = 10'h3FF; sram_we = 1'b1; sram_datao = 32'h1234_5678;
        @(negedge clk);
        sram_we = 1'b0;
        @(negedge clk);
        chk("ram_rd_3ff", sram_datai, 32'h1234_5678);

        stat = 16'h0004; stat_src = 4'd2;
        @(negedge clk);
        chk("status_src2", disp_status, 1'b1);
        stat_src = 4'd3;
        @(negedge clk);
        chk("status_src3", disp_status, 1'b0);

        disp_ena = 1'b1; disp_page = 8'h08;
        run_frame(bits, lf, lc, rs);
        chk("p8_bits", bits, {32'h8000_0001, 96'h0});
        chk("p8_rises", rs, 128);
        chk("p8_lat_first", lf, 517);
        chk("p8_lat_cnt", lc, 2);

        disp_page = 8'h00; cur_time = {9{4'h8}};
        tsc_1pps = 1'b1;
        @(negedge clk);
        tsc_1pps = 1'b0;
        run_frame(bits, lf, lc, rs);
        chk("p0_bits", bits, 128'h7FFF7FFF_7F7F7F7F_7F000000_00000000);
        chk("p0_lat_cnt", lc, 2);

        pdm_count(8'hAA, lows);
        chk("pdm_aa", lows, 170);
        pdm_count(8'h00, lows);
        chk("pdm_00", lows, 0);
        pdm_count(8'hFF, lows);
        chk("pdm_ff", lows, 255);

        disp_page = 8'h08;
        tsc_1ppms = 1'b1;
        @(negedge clk);
        tsc_1ppms = 1'b0;
        repeat (100) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_mid_sclk", disp_sclk, 1'b0);
        chk("rst_mid_lat", disp_lat, 1'b0);
        chk("rst_mid_blank", disp_blank, 1'b1);
        rst = 1'b0;
        @(negedge clk);
        run_frame(bits, lf, lc, rs);
        chk("post_rst_bits", bits, {32'h8000_0001, 96'h0});
        chk("post_rst_rises", rs, 128);
        chk("post_rst_lat", lf, 517);

        // randomized traffic checked against the model
        for (int c = 0; c < 9000; c++) begin
            rst = ($urandom_range(0, 2999) == 0);
            tsc_1ppms = ($urandom_range(0, 39) == 0);
            tsc_1pps = ($urandom_range(0, 299) == 0);
            tsc_1ppus = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 499) == 0) disp_ena = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 699) == 0)
                disp_page = ($urandom_range(0, 2) == 0) ? 8'h00 : 8'($urandom());
            if ($urandom_range(0, 199) == 0) disp_pdm = 8'($urandom());
            stat = 16'($urandom());
            stat_src = 4'($urandom());
            t64 = {$urandom(), $urandom()};
            cur_time = t64[35:0];
            sram_we = !rst && ($urandom_range(0, 3) == 0);
            sram_addr = 10'($urandom());
            sram_datao = $urandom();
            @(negedge clk);
        end
        rst = 1'b0; tsc_1ppms = 1'b0; tsc_1pps = 1'b0; tsc_1ppus = 1'b0;
        sram_we = 1'b0;
        repeat (530) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/disp.md
DISP -- requirements
Module: disp

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset: clk input 1 (rising-edge clock, all logic); rst input 1 (synchronous, active-high reset).
REQ-002 Timebase inputs, 1 bit each, one-clk strobes: tsc_1pps (second), tsc_1ppms (millisecond), tsc_1ppus (microsecond).
REQ-003 disp_ena input 1: display enable; disp_page input 8: frame page select; disp_pdm input 8: brightness.
REQ-004 stat_src input 4: status bit select; stat input 16: status vector.
REQ-005 CPU memory port: sram_addr input 10 (word address); sram_we input 1 (write strobe); sram_datao input 32 (write data); sram_datai output 32 (read data).
REQ-006 cur_time input time_t: BCD time of day.
REQ-007 TLC59282 outputs, 1 bit each: disp_sclk, disp_blank, disp_lat, disp_sin; disp_status output 1: status LED.

Function
REQ-008 Internal RAM SHALL be 1024x32 and dual-port, with a CPU port and a display read port.
REQ-009 CPU write: mem[sram_addr] <= sram_datao when sram_we=1.
REQ-010 CPU read: sram_datai <= mem[sram_addr] every clock, 1-cycle latency. On a simultaneous write to the same address, sram_datai returns the old data.
REQ-011 Frame: 128 bits built from page words {disp_page,2'b00}..{disp_page,2'b11}. Word0[31] is bit 127 and is shifted first. Byte k = frame bits 127-8k..120-8k.
REQ-012 When disp_page==0x00, bytes 0..8 SHALL be ORed with 7-seg codes of t_10h, t_1h, t_10m, t_1m, t_10s, t_1s, t_100ms, t_10ms, t_1ms.
REQ-013 7-seg encoding: bit0=a..bit6=g, bit7=dp; 0-9 = 3F,06,5B,4F,66,6D,7D,07,7F,6F; values >9 = 00.
REQ-014 A colon flag SHALL toggle on each tsc_1pps. While the flag is 1 on page 0, dp of bytes 1 and 3 SHALL be set.
REQ-015 Refresh start: on tsc_1ppms with disp_ena=1 and the controller IDLE, snapshot cur_time and fetch the 4 words in 5 clks into a 128-bit shift register.
REQ-016 tsc_1ppms while busy SHALL be ignored.
REQ-017 State machine: IDLE -> FETCH (5 clk) -> SHIFT (128 bits) -> LATCH (2 clk) -> IDLE.
REQ-018 SHIFT: disp_sclk period 4 clk (low 2, high 2). disp_sin SHALL update while sclk is low and be stable across each rising edge.
REQ-019 LATCH: disp_lat=1 for 2 clk with sclk=0. Frame period = 5+512+2 = 519 clk.
REQ-020 PDM: on each tsc_1ppus, {carry,acc} = acc + disp_pdm (8-bit acc). disp_blank = ~carry registered, held between strobes.
REQ-021 disp_pdm=0x00 SHALL give blank always 1; 0xFF SHALL give 255 on-strobes per 256; 0x80 SHALL alternate.
REQ-022 disp_ena=0: disp_blank=1, no new refresh starts; a refresh in progress completes.
REQ-023 disp_status = stat[stat_src], registered 1 clk.

Reset
REQ-024 rst SHALL force: state IDLE, sclk=0, lat=0, sin=0, blank=1, status=0, sram_datai=0, acc=0, colon flag=0.
REQ-025 RAM contents SHALL NOT be cleared by reset.
REQ-026 Reset mid-frame SHALL abort immediately with no latch pulse.

Structure
REQ-027 time_t SHALL be a packed struct in types_pkg with 4-bit BCD fields t_1ms, t_10ms, t_100ms, t_1s, t_10s, t_1m, t_10m, t_1h, t_10h.
REQ-028 Segment code constants SHALL live in types_pkg.
REQ-029 Sub-module disp_sram: 1024x32 dual-port RAM.

Verification
REQ-030 Write 0x8000_0001 to addr 0x020, set page 0x08, pulse 1ppms -> sin=1 on the 1st and 32nd sclk rise, 0 elsewhere in word0; one lat pulse at clk 517-518.
REQ-031 Page 0x00, RAM zero, cur_time all 8 -> bytes 0..8 = 0x7F (0xFF for bytes 1,3 after odd pps count), bytes 9..15 = 0x00.
REQ-032 disp_pdm 0xAA over 256 1ppus strobes -> blank low 170 times; 0x00 -> never low; 0xFF -> low 255 times.
REQ-033 CPU write 0x1234_5678 at addr 0x3FF then read it -> sram_datai=0x1234_5678 one clk after the address is applied.
REQ-034 stat=0x0004, stat_src=2 -> disp_status=1; stat_src=3 -> 0.
REQ-035 Assert rst mid-SHIFT -> next clk: sclk=0, lat=0, blank=1; the next 1ppms after release starts a full frame.
